// File: rtl/cp0_timer_bank.sv
// cp0_timer_bank: free-running Count with prescaler plus NUM_CMP Compare
// channels, each with a sticky interrupt-pending bit for Cause.IP merging.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   count_en       Count/prescaler advance enable (inverse of Cause.DC)
//   we/waddr/wdata register write (0 = Count, k+1 = Compare[k])
//   raddr/rdata    combinational read port (no write bypass)
//   irq            per-channel pending bits (registered)
//   irq_any        OR of pending bits (registered)
//   irq_lowest     index of lowest pending bit, 0 when none (registered)
module cp0_timer_bank #(
  parameter int unsigned COUNT_W     = 32,
  parameter int unsigned NUM_CMP     = 2,
  parameter int unsigned DIV         = 2,
  parameter int unsigned ZERO_DISARM = 1,
  parameter int unsigned ADDR_W      = $clog2(NUM_CMP + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               count_en,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [COUNT_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [COUNT_W-1:0] rdata,
  output logic [NUM_CMP-1:0] irq,
  output logic               irq_any,
  output logic [2:0]         irq_lowest
);

  localparam int unsigned PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IRQ_ADDR = NUM_CMP + 1;

  logic [PRE_W-1:0]   pre_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] cmp_q [NUM_CMP];

  logic               tick_c;
  logic               count_we_c;
  logic [NUM_CMP-1:0] cmp_we_c;
  logic [NUM_CMP-1:0] match_c;
  logic [NUM_CMP-1:0] irq_nxt_c;
  logic [2:0]         lowest_c;

  // Prescaler terminal count; with DIV = 1 every enabled cycle ticks.
  always_comb begin
    tick_c = 1'b0;
    if (DIV == 1) begin
      tick_c = count_en;
    end else begin
      tick_c = count_en && (pre_q == PRE_W'(DIV - 1));
    end
  end

  // Write decode, match detection and next-state pending bits.
  always_comb begin
    count_we_c = we && (waddr == '0);
    cmp_we_c   = '0;
    match_c    = '0;
    irq_nxt_c  = '0;
    for (int unsigned k = 0; k < NUM_CMP; k++) begin
      cmp_we_c[k]  = we && (waddr == ADDR_W'(k + 1));
      match_c[k]   = (count_q == cmp_q[k]) &&
                     ((ZERO_DISARM == 0) || (cmp_q[k] != '0));
      // Compare write clears the pending bit and beats a same-cycle match.
      irq_nxt_c[k] = cmp_we_c[k] ? 1'b0 : (irq[k] | match_c[k]);
    end
  end

  // Lowest set pending bit of the next-state vector.
  always_comb begin
    lowest_c = 3'd0;
    for (int k = int'(NUM_CMP) - 1; k >= 0; k--) begin
      if (irq_nxt_c[k]) begin
        lowest_c = 3'(k);
      end
    end
  end

  // Prescaler and Count; a Count write restarts the prescaler and wins over a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      count_q <= '0;
    end else if (count_we_c) begin
      pre_q   <= '0;
      count_q <= wdata;
    end else if (count_en) begin
      pre_q <= (DIV == 1 || tick_c) ? '0 : pre_q + PRE_W'(1);
      if (tick_c) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  // Compare registers and interrupt state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_CMP; k++) begin
        cmp_q[k] <= '0;
      end
      irq        <= '0;
      irq_any    <= 1'b0;
      irq_lowest <= 3'd0;
    end else begin
      for (int unsigned k = 0; k < NUM_CMP; k++) begin
        if (cmp_we_c[k]) begin
          cmp_q[k] <= wdata;
        end
      end
      irq        <= irq_nxt_c;
      irq_any    <= |irq_nxt_c;
      irq_lowest <= lowest_c;
    end
  end

  // Combinational read port showing registered (pre-write) contents.
  always_comb begin
    rdata = '0;
    if (raddr == '0) begin
      rdata = count_q;
    end else if (raddr == ADDR_W'(IRQ_ADDR)) begin
      rdata = COUNT_W'(irq);
    end else begin
      for (int unsigned k = 0; k < NUM_CMP; k++) begin
        if (raddr == ADDR_W'(k + 1)) begin
          rdata = cmp_q[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_timer_bank.sv
// Directed bench for cp0_timer_bank: four instances (DIV=2, DIV=1 with and
// without zero-disarm, DIV=4) share one stimulus stream; each phase checks
// the instance whose parameters it targets.
module tb_cp0_timer_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        count_en;
  logic        we;
  logic [1:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  raddr;

  logic [31:0] rdata_d2, rdata_d1, rdata_z0, rdata_d4;
  logic [1:0]  irq_d2, irq_d1, irq_z0, irq_d4;
  logic        any_d2, any_d1, any_z0, any_d4;
  logic [2:0]  low_d2, low_d1, low_z0, low_d4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cp0_timer_bank #(.DIV(2), .ZERO_DISARM(1)) u_d2 (
    .clk(clk), .rst(rst), .count_en(count_en), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata_d2), .irq(irq_d2),
    .irq_any(any_d2), .irq_lowest(low_d2));

  cp0_timer_bank #(.DIV(1), .ZERO_DISARM(1)) u_d1 (
    .clk(clk), .rst(rst), .count_en(count_en), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata_d1), .irq(irq_d1),
    .irq_any(any_d1), .irq_lowest(low_d1));

  cp0_timer_bank #(.DIV(1), .ZERO_DISARM(0)) u_z0 (
    .clk(clk), .rst(rst), .count_en(count_en), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata_z0), .irq(irq_z0),
    .irq_any(any_z0), .irq_lowest(low_z0));

  cp0_timer_bank #(.DIV(4), .ZERO_DISARM(1)) u_d4 (
    .clk(clk), .rst(rst), .count_en(count_en), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata_d4), .irq(irq_d4),
    .irq_any(any_d4), .irq_lowest(low_d4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step(1);
    we = 1'b0;
  endtask

  task automatic rd_at(input logic [1:0] a);
    raddr = a;
    #1;
  endtask

  initial begin
    rst = 1'b1; count_en = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    step(1);

    // Reset state
    check("rst_count", rdata_d2, 32'd0);
    check("rst_irq", 32'(irq_d2), 32'd0);
    check("rst_any", 32'(any_d2), 32'd0);
    check("rst_lowest", 32'(low_d2), 32'd0);
    rd_at(2'd1); check("rst_cmp0", rdata_d2, 32'd0);

    // DIV=2: 10 enabled cycles give count 5
    rst = 1'b0; count_en = 1'b1; rd_at(2'd0);
    step(10);
    check("div2_count10", rdata_d2, 32'd5);
    check("div2_irq", 32'(irq_d2), 32'd0);

    // DIV=1: Compare[1]=3, irq[1] one cycle after count==3
    rst = 1'b1; count_en = 1'b0; step(1); rst = 1'b0;
    wr(2'd2, 32'd3);
    count_en = 1'b1; rd_at(2'd0);
    step(3);
    check("c3_count", rdata_d1, 32'd3);
    check("c3_irq_not_yet", 32'(irq_d1), 32'd0);
    step(1);
    check("c4_irq", 32'(irq_d1), 32'd2);
    check("c4_any", 32'(any_d1), 32'd1);
    check("c4_lowest", 32'(low_d1), 32'd1);
    rd_at(2'd3); check("c4_rd_irq", rdata_d1, 32'd2);
    step(1);
    rd_at(2'd0); check("c5_count", rdata_d1, 32'd5);
    check("c5_irq_sticky", 32'(irq_d1), 32'd2);

    // Raise irq[0] too, then clear only irq[1] via Compare[1] write
    wr(2'd1, 32'd7);          // count 6
    step(2);                  // count 8, match seen at 7
    check("both_irq", 32'(irq_d1), 32'd3);
    check("both_lowest", 32'(low_d1), 32'd0);
    we = 1'b1; waddr = 2'd2; wdata = 32'd100; rd_at(2'd2);
    check("rd_no_bypass", rdata_d1, 32'd3);
    step(1); we = 1'b0;
    check("clr1_irq", 32'(irq_d1), 32'd1);
    check("clr1_lowest", 32'(low_d1), 32'd0);
    check("clr1_any", 32'(any_d1), 32'd1);
    check("clr1_cmp1", rdata_d1, 32'd100);

    // Count wrap with Compare[0]=0: disarmed vs armed
    rst = 1'b1; count_en = 1'b0; step(1); rst = 1'b0;
    wr(2'd0, 32'hFFFF_FFFE);
    wr(2'd1, 32'd0);          // clears irq[0] raised by the reset-time match on u_z0
    check("z0_cleared", 32'(irq_z0[0]), 32'd0);
    count_en = 1'b1; rd_at(2'd0);
    step(2);
    check("wrap_count_zd1", rdata_d1, 32'd0);
    check("wrap_count_zd0", rdata_z0, 32'd0);
    check("wrap_irq_zd0_not_yet", 32'(irq_z0[0]), 32'd0);
    step(1);
    check("wrap_irq_zd1", 32'(irq_d1), 32'd0);
    check("wrap_irq_zd0", 32'(irq_z0[0]), 32'd1);

    // Same-cycle match and Compare[0] write: write wins
    rst = 1'b1; count_en = 1'b0; step(1); rst = 1'b0;
    wr(2'd0, 32'd7);
    wr(2'd1, 32'd7);
    wr(2'd1, 32'd9);
    check("cmpwr_wins", 32'(irq_d1), 32'd0);
    count_en = 1'b1; rd_at(2'd0);
    step(2);
    check("c9_count", rdata_d1, 32'd9);
    check("c9_irq_not_yet", 32'(irq_d1), 32'd0);
    step(1);
    check("c10_irq", 32'(irq_d1), 32'd1);

    // Writes to the irq address are ignored
    count_en = 1'b0;
    wr(2'd3, 32'hFF);
    rd_at(2'd0); check("ign_count", rdata_d1, 32'd10);
    rd_at(2'd1); check("ign_cmp0", rdata_d1, 32'd9);
    rd_at(2'd2); check("ign_cmp1", rdata_d1, 32'd0);
    rd_at(2'd3); check("ign_irq", rdata_d1, 32'd1);

    // Match on old count still sets irq during a Count write
    wr(2'd1, 32'd10);
    check("cmp10_clear", 32'(irq_d1), 32'd0);
    wr(2'd0, 32'd50);
    rd_at(2'd0); check("cntwr_count", rdata_d1, 32'd50);
    check("cntwr_irq", 32'(irq_d1), 32'd1);

    // DIV=4: freeze mid-prescale, resume, then reset mid-run
    rst = 1'b1; step(1); rst = 1'b0;
    count_en = 1'b1; rd_at(2'd0);
    step(6);
    check("d4_count6", rdata_d4, 32'd1);
    count_en = 1'b0;
    step(5);
    check("d4_frozen", rdata_d4, 32'd1);
    count_en = 1'b1;
    step(1);
    check("d4_resume1", rdata_d4, 32'd1);
    step(1);
    check("d4_resume2", rdata_d4, 32'd2);
    step(1);
    rst = 1'b1; step(1); rst = 1'b0;
    check("d4_rst_count", rdata_d4, 32'd0);
    step(3);
    check("d4_rst_pre3", rdata_d4, 32'd0);
    step(1);
    check("d4_rst_pre4", rdata_d4, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_timer_bank.md
Name: cp0_timer_bank

Overview:
- Parametrised successor to the single Count/Compare timer inside cp0.
- Provides one free-running Count with a programmable prescaler, plus NUM_CMP independent Compare channels.
- Each channel has a sticky interrupt-pending bit; all of them are exported for Cause.IP merging.
- Sits beside cp0 and is driven from the WB-stage CP0 write request; cp0 reads it through a combinational read port.

Parameters:
- COUNT_W, 32: width of Count, each Compare, wdata and rdata.
- NUM_CMP, 2: number of Compare channels, 1..8.
- DIV, 2: Count increments once every DIV enabled clk cycles, 1..256.
- ZERO_DISARM, 1: when 1, a Compare value of 0 never raises its interrupt.
- ADDR_W, $clog2(NUM_CMP+2): register address width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- count_en, in, 1: Count runs when 1 (inverse of Cause.DC).
- we, in, 1: register write strobe.
- waddr, in, ADDR_W: 0 = Count; k+1 = Compare[k].
- wdata, in, COUNT_W: write data.
- raddr, in, ADDR_W: read address.
- rdata, out, COUNT_W: combinational read data.
- irq, out, NUM_CMP: per-channel pending bits, registered.
- irq_any, out, 1: OR of irq, registered.
- irq_lowest, out, 3: index of the lowest set irq bit; 0 when none is set.

Behaviour:
- Reset values:
  - count = 0, every compare = 0, prescaler = 0.
  - irq = 0, irq_any = 0, irq_lowest = 0.
  - rdata follows the reset register contents.
- Prescaler:
  - While count_en = 1, increments each cycle; at DIV-1 it wraps to 0 and generates tick.
  - While count_en = 0, prescaler and count both hold.
  - DIV = 1: tick is every enabled cycle and the prescaler stays at 0.
- Count:
  - On tick, count <= count + 1, modulo 2^COUNT_W. All-ones wraps to 0 with no flag.
- Count write (we, waddr = 0):
  - count <= wdata, prescaler <= 0.
  - The tick increment is suppressed that cycle; the write wins.
- Compare write (we, waddr = k+1):
  - compare[k] <= wdata and irq[k] <= 0 (MIPS clear-on-Compare-write).
- Match:
  - match[k] = (count == compare[k]), evaluated on the current registered values.
  - If ZERO_DISARM = 1, match[k] is additionally gated by compare[k] != 0.
  - A match sets irq[k] at the next edge. irq[k] is sticky until a Compare[k] write or reset.
  - irq[k] stays set while count remains equal, e.g. when count_en = 0.
- Simultaneous match and Compare[k] write in one cycle: the write wins and irq[k] = 0 after the edge. The new compare is evaluated from the following cycle.
- Simultaneous match and Count write: the match uses the old count and still sets irq. The written count is evaluated from the next cycle.
- Writes to addresses >= NUM_CMP+1 are ignored.
- Read map:
  - raddr 0: count.
  - raddr 1..NUM_CMP: compare[raddr-1].
  - raddr NUM_CMP+1: irq zero-extended.
  - All other addresses return 0.
  - Reads show pre-write values in the write cycle (no bypass).
- irq_any and irq_lowest are registered copies derived from the next-state irq vector. They change on the same edge as irq.
- Latency:
  - Count equal to compare, to irq visible: 1 cycle.
  - Compare write, to irq cleared: 1 cycle.
- Reset mid-count clears all state in one edge. There is no partial prescaler carry-over.
- Implementation is synthesisable with flops only and no memories.

Test Plan:
- Reset, DIV=2, count_en=1, 10 cycles -> count = 5 at cycle 10, rdata(raddr=0) = 5, irq = 0.
- Write Compare[1]=3, DIV=1 -> irq[1] rises one cycle after count==3. It remains 1 after count=4. irq_any=1, irq_lowest=1, rdata(raddr=3)=0b10.
- With irq[1] set, write Compare[1]=100 -> irq[1]=0 next cycle. irq[0] is unaffected.
- Count write 0xFFFF_FFFE, DIV=1, Compare[0]=0, ZERO_DISARM=1 -> count wraps to 0 after 2 cycles and irq[0] stays 0. Rerun with ZERO_DISARM=0 -> irq[0] sets one cycle after the wrap.
- Same-cycle match and Compare[0] write (count=7, compare[0]=7, write 9) -> irq[0]=0 after the edge. irq[0] later sets one cycle after count==9.
- count_en=0 for 5 cycles mid-prescale (DIV=4, prescaler=2) -> count and prescaler frozen. Resuming gives the next tick after exactly 2 cycles. Asserting rst mid-run zeroes all state next edge.
